// File: rtl/pipe_regfile_if.sv
// ---------------------------------------------------------------------------
// pipe_regfile_if
//   Bundles the write, read and issue signals of the pipelined register file.
//   The master side (ID/WB stages, or a testbench) drives addresses, data and
//   enables; the slave side (pipe_regfile) returns read data and busy flags.
//
//   Signals
//     wr_en    [NW]      per-port write enable
//     wr_clr   [NW]      per-port: the write also clears the busy bit
//     wr_addr  [NW*AW]   packed write addresses, port i at [i*AW +: AW]
//     wr_data  [NW*DW]   packed write data, port i at [i*DW +: DW]
//     rd_addr  [NR*AW]   packed read addresses
//     rd_data  [NR*DW]   packed read data (combinational)
//     rd_busy  [NR]      busy flag of each read address (combinational)
//     iss_en   [1]       issue: mark iss_addr as having a pending producer
//     iss_addr [AW]      destination register of the issued instruction
// ---------------------------------------------------------------------------
interface pipe_regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 2
);
  logic [NW-1:0]    wr_en;
  logic [NW-1:0]    wr_clr;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;

  modport master (
    output wr_en, wr_clr, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  wr_en, wr_clr, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/pipe_regfile.sv
// ---------------------------------------------------------------------------
// pipe_regfile
//   Multi-port general register file for the pipelined MIPS core, with a
//   per-register busy scoreboard used by the hazard unit. Reads and issues
//   happen in ID, writes and busy clears in WB.
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (clears registers and busy bits)
//     bus   pipe_regfile_if.slave: write ports, read ports, issue port
//
//   Parameters
//     DW data width, AW address width (depth 2**AW, register 0 reads as 0),
//     NR read ports, NW write ports (highest index wins on collisions).
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, reads forward same-cycle write data and
//                        rd_busy shows a same-cycle clear; when undefined,
//                        reads show registered state only.
// ---------------------------------------------------------------------------
module pipe_regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 2
) (
  input  logic           clk,
  input  logic           rst,
  pipe_regfile_if.slave  bus
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Scoreboard next state: clears first, then the issue set, so a set and a
  // clear of the same register in one cycle leaves it busy.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned (which would infer a latch); blocking '=' is used here so
    // later statements see earlier updates.
    busy_d = busy_q;
    for (int i = 0; i < NW; i++) begin
      if (bus.wr_en[i] && bus.wr_clr[i]) begin
        busy_d[bus.wr_addr[i*AW +: AW]] = 1'b0;
      end
    end
    if (bus.iss_en) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking '<=' so all flops sample the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register array. Ports are visited in ascending order; the last
  // non-blocking assignment to an address wins, giving the highest port
  // priority on collisions. Address 0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: clearing the whole array on reset rules out a RAM macro and
      // costs a wide reset fan-out; it is kept because the core relies on
      // every register reading zero after reset.
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i*AW +: AW] != '0)) begin
          regs_q[bus.wr_addr[i*AW +: AW]] <= bus.wr_data[i*DW +: DW];
        end
      end
    end
  end

  // Read ports: combinational, register 0 always reads as zero / not busy.
  always_comb begin
    logic [AW-1:0] ra;
`ifdef REGFILE_BYPASS_EN
    logic          clr_hit;
`endif
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int j = 0; j < NR; j++) begin
      ra = bus.rd_addr[j*AW +: AW];
      if (ra != '0) begin
        bus.rd_data[j*DW +: DW] = regs_q[ra];
        bus.rd_busy[j]          = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed during reset because those writes are
        // discarded at the edge anyway.
        clr_hit = 1'b0;
        if (!rst) begin
          for (int i = 0; i < NW; i++) begin
            if (bus.wr_en[i] && (bus.wr_addr[i*AW +: AW] == ra)) begin
              bus.rd_data[j*DW +: DW] = bus.wr_data[i*DW +: DW];
              if (bus.wr_clr[i]) begin
                clr_hit = 1'b1;
              end
            end
          end
          // A same-cycle issue to this register re-arms it, so the clear is
          // only shown when no new producer is being issued.
          if (clr_hit && !(bus.iss_en && (bus.iss_addr == ra))) begin
            bus.rd_busy[j] = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipe_regfile.sv
// ---------------------------------------------------------------------------
// tb_pipe_regfile
//   Self-checking bench for pipe_regfile: reset sweep, a table of directed
//   vectors covering write, collision, address 0, scoreboard set/clear/reset
//   corner cases, then randomized traffic against a behavioural model.
//   Expectations follow REGFILE_BYPASS_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_pipe_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int DEPTH = 1 << AW;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_regfile_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();

  pipe_regfile #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];

  function automatic logic [AW-1:0] in_wa(input int i);
    return bus.wr_addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] in_wd(input int i);
    return bus.wr_data[i*DW +: DW];
  endfunction

  // Expected read data for address ra given current inputs and model state.
  function automatic logic [DW-1:0] m_rd_data(input logic [AW-1:0] ra);
    if (ra == 0) return '0;
    if (BYP && !rst) begin
      for (int i = NW - 1; i >= 0; i--) begin
        if (bus.wr_en[i] && in_wa(i) == ra) return in_wd(i);
      end
    end
    return m_regs[ra];
  endfunction

  function automatic logic m_rd_busy(input logic [AW-1:0] ra);
    bit cleared;
    if (ra == 0) return 1'b0;
    cleared = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (bus.wr_en[i] && bus.wr_clr[i] && in_wa(i) == ra) cleared = 1'b1;
    end
    if (BYP && !rst && cleared && !(bus.iss_en && bus.iss_addr == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic m_edge();
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (bus.wr_en[i] && in_wa(i) != 0) m_regs[in_wa(i)] = in_wd(i);
        if (bus.wr_en[i] && bus.wr_clr[i]) m_busy[in_wa(i)] = 1'b0;
      end
      if (bus.iss_en && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
    end
  endtask

  // Advance one clock: model follows the DUT at the rising edge, new inputs
  // are driven on the falling edge.
  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [1:0] wen, input logic [1:0] wclr,
                       input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                       input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                       input logic iss, input logic [AW-1:0] ia,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic [AW-1:0] ra2);
    rst          = r;
    bus.wr_en    = wen;
    bus.wr_clr   = wclr;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.iss_en   = iss;
    bus.iss_addr = ia;
    bus.rd_addr  = {ra2, ra1, ra0};
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          r;
    logic [1:0]    wen;
    logic [1:0]    wclr;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic          iss;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] ed0;
    logic          eb0;
    logic [DW-1:0] ed1;
    logic          eb1;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic r, input logic [1:0] wen, input logic [1:0] wclr,
                              input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                              input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                              input logic iss, input logic [AW-1:0] ia,
                              input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                              input logic [DW-1:0] ed0, input logic eb0,
                              input logic [DW-1:0] ed1, input logic eb1);
    vec_t v;
    v.r = r; v.wen = wen; v.wclr = wclr; v.wa0 = wa0; v.wa1 = wa1;
    v.wd0 = wd0; v.wd1 = wd1; v.iss = iss; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1;
    return v;
  endfunction

  initial begin
    logic [AW-1:0] a0, a1, a2, ia;

    drive(1'b1, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    tick();  // one reset edge

    // Reset state: every address on every port reads 0 and not busy.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 2'b00, 2'b00, '0, '0, '0, '0, 1'b0, '0, AW'(a), AW'(a), AW'(a));
      #1;
      for (int j = 0; j < NR; j++) begin
        check($sformatf("reset_data[a=%0d,p=%0d]", a, j), bus.rd_data[j*DW +: DW], '0);
        check($sformatf("reset_busy[a=%0d,p=%0d]", a, j), DW'(bus.rd_busy[j]), '0);
      end
    end

    //            r   wen    wclr   wa0 wa1 wd0           wd1       iss ia  ra0 ra1 ed0                                   eb0            ed1        eb1
    vecs.push_back(mk(0, 2'b01, 2'b00, 5,  0, 32'hDEADBEEF, 0,        0,  0,  5,  0,  BYP ? 32'hDEADBEEF : 32'h0,           0,             0,         0));
    vecs.push_back(mk(0, 2'b01, 2'b00, 0,  0, 32'h1234,     0,        0,  0,  5,  0,  32'hDEADBEEF,                         0,             0,         0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 7,  7, 32'h11,       32'h22,   0,  0,  7,  0,  BYP ? 32'h22 : 32'h0,                 0,             0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        0,  0,  7,  0,  32'h22,                               0,             0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        1,  9,  9,  7,  0,                                    0,             32'h22,    0));
    vecs.push_back(mk(0, 2'b01, 2'b01, 9,  0, 32'h99,       0,        1,  9,  9,  7,  BYP ? 32'h99 : 32'h0,                 1,             32'h22,    0));
    vecs.push_back(mk(0, 2'b01, 2'b01, 9,  0, 32'hAA,       0,        0,  0,  9,  7,  BYP ? 32'hAA : 32'h99,                BYP ? 0 : 1,   32'h22,    0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        0,  0,  9,  7,  32'hAA,                               0,             32'h22,    0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        1,  3,  3,  9,  0,                                    0,             32'hAA,    0));
    vecs.push_back(mk(1, 2'b10, 2'b00, 0,  3, 0,            32'h55,   0,  0,  3,  9,  0,                                    1,             32'hAA,    0));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0,  0, 0,            0,        0,  0,  3,  9,  0,                                    0,             0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        0,  0,  3,  7,  0,                                    0,             0,         0));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 12, 0,            32'hC,    0,  0, 12,  0,  BYP ? 32'hC : 32'h0,                  0,             0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        0,  0, 12,  0,  32'hC,                                0,             0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        1, 12, 12,  0,  32'hC,                                0,             0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        1, 12, 12,  0,  32'hC,                                1,             0,         0));
    vecs.push_back(mk(0, 2'b01, 2'b01, 12, 0, 32'hD,        0,        0,  0, 12,  0,  BYP ? 32'hD : 32'hC,                  BYP ? 0 : 1,   0,         0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 0,            0,        0,  0, 12,  0,  32'hD,                                0,             0,         0));

    foreach (vecs[k]) begin
      drive(vecs[k].r, vecs[k].wen, vecs[k].wclr, vecs[k].wa0, vecs[k].wa1,
            vecs[k].wd0, vecs[k].wd1, vecs[k].iss, vecs[k].ia,
            vecs[k].ra0, vecs[k].ra1, '0);
      #1;
      check($sformatf("vec%0d_rd_data0", k), bus.rd_data[0 +: DW],  vecs[k].ed0);
      check($sformatf("vec%0d_rd_busy0", k), DW'(bus.rd_busy[0]),   DW'(vecs[k].eb0));
      check($sformatf("vec%0d_rd_data1", k), bus.rd_data[DW +: DW], vecs[k].ed1);
      check($sformatf("vec%0d_rd_busy1", k), DW'(bus.rd_busy[1]),   DW'(vecs[k].eb1));
      tick();
    end

    // Randomized traffic; small address range most of the time to force
    // collisions, set/clear races and re-issues.
    for (int c = 0; c < 4000; c++) begin
      a0 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      a1 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      ia = AW'($urandom_range(0, 7));
      drive(($urandom % 64) == 0, 2'($urandom), 2'($urandom), a0, a1,
            DW'($urandom), DW'($urandom), 1'($urandom), ia,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom));
      #1;
      for (int j = 0; j < NR; j++) begin
        a2 = bus.rd_addr[j*AW +: AW];
        check($sformatf("rand%0d_rd_data%0d", c, j), bus.rd_data[j*DW +: DW], m_rd_data(a2));
        check($sformatf("rand%0d_rd_busy%0d", c, j), DW'(bus.rd_busy[j]), DW'(m_rd_busy(a2)));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
